instr_stream_encoder: RTL and testbench
=======================================

// Module: instr_stream_encoder
// PURPOSE
//  Encodes symbolic LEGv8 instructions (op + register/immediate fields) into
//  32-bit words and writes them sequentially into instruction memory. It is
//  the write-side counterpart of the control decoder: it emits opcodes that
//  decoder accepts. Sits between the testbench/boot loader and imem, before
//  the core is released from reset.
// PARAMETERS
//  ADDR_W  64   width of imem byte address
//  DEPTH   256  max words per load session
//  CNT_W   9    width of count; must satisfy 2**CNT_W > DEPTH
// PORTS
//  CLK         in   1       clock, rising edge
//  reset       in   1       synchronous, active-high
//  start       in   1       begin a load session (ignored unless IDLE)
//  base_addr   in   ADDR_W  byte address of first word; sampled on start
//  in_valid    in   1       instruction beat valid
//  in_ready    out  1       beat accepted when in_valid & in_ready
//  in_last     in   1       marks final beat of session
//  in_op       in   4       0 ADD,1 SUB,2 AND,3 ORR,4 LDUR,5 STUR,6 CBZ,7 B,8 MOVZ; others illegal
//  in_rd       in   5       Rd/Rt
//  in_rn       in   5       Rn
//  in_rm       in   5       Rm
//  in_imm      in   26      immediate, two's complement except MOVZ (unsigned)
//  in_hw       in   2       MOVZ shift selector (LSL 16*hw)
//  imem_we     out  1       one-cycle write strobe
//  imem_addr   out  ADDR_W  write byte address
//  imem_wdata  out  32      encoded word
//  busy        out  1       high in ACCEPT and FINISH
//  done        out  1       one-cycle pulse at session end
//  err         out  1       sticky: illegal op, imm out of range, or overflow
//  count       out  CNT_W   words written this session
// BEHAVIOUR
//  Reset: state IDLE; in_ready, imem_we, busy, done, err = 0; count = 0;
//   imem_addr, imem_wdata = 0. Reset mid-session aborts; no write after it.
//  FSM IDLE -> ACCEPT on start (latch base_addr; clear count, err).
//   ACCEPT: in_ready = 1 while count < DEPTH. Accepted beat -> FINISH if in_last.
//   FINISH: in_ready = 0; done = 1 for exactly one cycle; -> IDLE.
//   start while not IDLE is ignored.
//  Latency: beat accepted at edge N -> imem_we = 1 in cycle N+1 (registered).
//   imem_addr = base_addr + 4*count (pre-increment); count += 1 at that edge.
//   Back-to-back beats yield one write per cycle. imem never backpressures.
//  Encodings [31:0]:
//   ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000:
//    {op11, rm, 6'b0, rn, rd}
//   LDUR 11111000010, STUR 11111000000: {op11, imm[8:0], 2'b00, rn, rd}
//   CBZ {8'b10110100, imm[18:0], rd}; B {6'b000101, imm[25:0]}
//   MOVZ {9'b110100101, hw, imm[15:0], rd}
//  Range checks: LDUR/STUR imm in [-256,255]; CBZ in [-2^18, 2^18-1]; MOVZ
//   imm < 2^16. B takes all 26 bits.
//  Failing beat or illegal op: still accepted (handshake completes); err set;
//   no write; count unchanged; in_last still ends session.
//  Overflow: count == DEPTH with in_valid high and no in_last -> err = 1,
//   FSM -> FINISH. Beats are never silently dropped while in_ready = 1.
//  Address arithmetic wraps modulo 2^ADDR_W; no error on wrap.
// STRUCTURE
//  Shared package legv8_isa_pkg: in_op enum; 11-bit opcode constants; field
//   widths. The control decoder's casez patterns are derived from these.
//  Sub-module instr_field_encoder (combinational): op/fields -> word + legal flag.
//  Top: FSM, count/address registers, output register stage.
// TESTING
//  ADD rd=3,rn=1,rm=2 -> imem_wdata 0x8B020023 at base_addr, count 1
//  LDUR rd=5,rn=6,imm=8 -> 0xF84080C5; STUR same fields -> 0xF80080C5
//  B imm=-1 -> 0x17FFFFFF; CBZ rd=7,imm=4 -> 0xB4000087
//  MOVZ rd=9,imm=0x1234,hw=1 -> 0xD2A24689
//  LDUR imm=300, then ADD+last -> err=1, one write only, at base_addr; done pulse
//  DEPTH=4, 5 back-to-back beats, no in_last -> 4 writes at base+0..12; err=1;
//   done; reset asserted mid-stream -> imem_we=0 next cycle, state IDLE

Source files
------------

// File: rtl/legv8_isa_pkg.sv
// LEGv8 ISA constants shared by the stream encoder and the control decoder.
// Opcode fields here are the single source for the decoder's casez patterns.
package legv8_isa_pkg;

  localparam int OP_W   = 4;
  localparam int REG_W  = 5;
  localparam int IMM_W  = 26;
  localparam int HW_W   = 2;
  localparam int WORD_W = 32;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_ORR  = 4'd3,
    OP_LDUR = 4'd4,
    OP_STUR = 4'd5,
    OP_CBZ  = 4'd6,
    OP_B    = 4'd7,
    OP_MOVZ = 4'd8
  } op_e;

  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
  localparam logic [5:0]  OPC_B    = 6'b000101;
  localparam logic [8:0]  OPC_MOVZ = 9'b110100101;

  // True when imm sign-extends from its low 'bits' bits.
  function automatic logic fits_signed(
    input logic [IMM_W-1:0] imm,
    input int               bits
  );
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < IMM_W; i++) begin
      if (i >= bits && imm[i] != imm[bits-1]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/instr_field_encoder.sv
// Combinational LEGv8 field packer: op and fields in, 32-bit word out.
// legal drops for unknown ops or immediates that do not fit their field.
module instr_field_encoder
  import legv8_isa_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [REG_W-1:0]  rd,
  input  logic [REG_W-1:0]  rn,
  input  logic [REG_W-1:0]  rm,
  input  logic [IMM_W-1:0]  imm,
  input  logic [HW_W-1:0]   hw,
  output logic [WORD_W-1:0] word,
  output logic              legal
);

  logic d_ok;
  logic cb_ok;
  logic mv_ok;

  assign d_ok  = fits_signed(imm, 9);
  assign cb_ok = fits_signed(imm, 19);
  assign mv_ok = (imm[IMM_W-1:16] == '0);

  always_comb begin
    word  = '0;
    legal = 1'b0;
    unique case (1'b1)
      (op == OP_ADD): begin
        word  = {OPC_ADD, rm, 6'b0, rn, rd};
        legal = 1'b1;
      end
      (op == OP_SUB): begin
        word  = {OPC_SUB, rm, 6'b0, rn, rd};
        legal = 1'b1;
      end
      (op == OP_AND): begin
        word  = {OPC_AND, rm, 6'b0, rn, rd};
        legal = 1'b1;
      end
      (op == OP_ORR): begin
        word  = {OPC_ORR, rm, 6'b0, rn, rd};
        legal = 1'b1;
      end
      (op == OP_LDUR): begin
        word  = {OPC_LDUR, imm[8:0], 2'b00, rn, rd};
        legal = d_ok;
      end
      (op == OP_STUR): begin
        word  = {OPC_STUR, imm[8:0], 2'b00, rn, rd};
        legal = d_ok;
      end
      (op == OP_CBZ): begin
        word  = {OPC_CBZ, imm[18:0], rd};
        legal = cb_ok;
      end
      (op == OP_B): begin
        word  = {OPC_B, imm};
        legal = 1'b1;
      end
      (op == OP_MOVZ): begin
        word  = {OPC_MOVZ, hw, imm[15:0], rd};
        legal = mv_ok;
      end
      default: begin
        word  = '0;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_stream_encoder.sv
// Load-session FSM: encodes accepted beats and writes them to imem
// one word per cycle from base_addr upward, flagging bad beats in err.
module instr_stream_encoder
  import legv8_isa_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DEPTH  = 256,
  parameter int CNT_W  = 9
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [OP_W-1:0]   in_op,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [REG_W-1:0]  in_rn,
  input  logic [REG_W-1:0]  in_rm,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [HW_W-1:0]   in_hw,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCEPT,
    S_FINISH
  } state_e;

  state_e state;
  state_e state_nx;

  logic [ADDR_W-1:0] base_q;
  logic [WORD_W-1:0] word;
  logic              legal;
  logic              full;
  logic              fire;
  logic              ovf;
  logic              open;

  instr_field_encoder u_enc (
    .op    (in_op),
    .rd    (in_rd),
    .rn    (in_rn),
    .rm    (in_rm),
    .imm   (in_imm),
    .hw    (in_hw),
    .word  (word),
    .legal (legal)
  );

  assign full = (count == CNT_W'(DEPTH));
  assign fire = in_valid & in_ready;
  // A full session facing another beat ends rather than stalling forever.
  assign ovf  = (state == S_ACCEPT) & full & in_valid;
  assign open = (state == S_IDLE) & start;

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_nx = S_ACCEPT;
      end
      S_ACCEPT: begin
        busy     = 1'b1;
        in_ready = ~full;
        if ((fire & in_last) | ovf) state_nx = S_FINISH;
      end
      S_FINISH: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state      <= S_IDLE;
      base_q     <= '0;
      count      <= '0;
      err        <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      state   <= state_nx;
      imem_we <= 1'b0;
      if (open) begin
        base_q <= base_addr;
        count  <= '0;
        err    <= 1'b0;
      end
      if (fire) begin
        if (legal) begin
          imem_we    <= 1'b1;
          imem_addr  <= base_q + ADDR_W'({count, 2'b00});
          imem_wdata <= word;
          count      <= count + CNT_W'(1);
        end else begin
          err <= 1'b1;
        end
      end
      if (ovf) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Scoreboard bench for instr_stream_encoder with a 4-word session depth.
// Expected writes are queued at drive time and checked by a write monitor.
module tb_instr_stream_encoder;

  logic        CLK;
  logic        reset;
  logic        start;
  logic [63:0] base_addr;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [3:0]  in_op;
  logic [4:0]  in_rd;
  logic [4:0]  in_rn;
  logic [4:0]  in_rm;
  logic [25:0] in_imm;
  logic [1:0]  in_hw;
  logic        imem_we;
  logic [63:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [2:0]  count;

  int total = 0;
  int bad = 0;
  logic [95:0] sb_q[$];
  logic [63:0] exp_addr;

  instr_stream_encoder #(
    .ADDR_W (64),
    .DEPTH  (4),
    .CNT_W  (3)
  ) dut (
    .CLK        (CLK),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_last    (in_last),
    .in_op      (in_op),
    .in_rd      (in_rd),
    .in_rn      (in_rn),
    .in_rm      (in_rm),
    .in_imm     (in_imm),
    .in_hw      (in_hw),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .count      (count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (imem_we === 1'b1) begin
      logic [95:0] e;
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write addr=%h data=%h",
                 imem_addr, imem_wdata);
      end else begin
        e = sb_q.pop_front();
        if ({imem_addr, imem_wdata} !== e) begin
          bad++;
          $display("FAIL write got=%h/%h want=%h/%h",
                   imem_addr, imem_wdata, e[95:32], e[31:0]);
        end
      end
    end
  end

  task automatic do_start(input logic [63:0] base);
    start     = 1'b1;
    base_addr = base;
    exp_addr  = base;
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  task automatic beat(
    input logic [3:0]  op,
    input logic [4:0]  rd,
    input logic [4:0]  rn,
    input logic [4:0]  rm,
    input logic [25:0] imm,
    input logic [1:0]  hw,
    input logic        last,
    input logic        wr,
    input logic [31:0] word
  );
    int n;
    in_op    = op;
    in_rd    = rd;
    in_rn    = rn;
    in_rm    = rm;
    in_imm   = imm;
    in_hw    = hw;
    in_last  = last;
    in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    if (in_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL ready_timeout got=%b want=1", in_ready);
      in_valid = 1'b0;
      return;
    end
    if (wr) begin
      sb_q.push_back({exp_addr, word});
      exp_addr = exp_addr + 64'd4;
    end
    @(posedge CLK); #1;
  endtask

  task automatic wait_done(input string name);
    int seen;
    seen = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge CLK);
      if (done === 1'b1) begin
        seen = 1;
        break;
      end
    end
    total++;
    if (seen == 0) begin
      bad++;
      $display("FAIL %s_done got=0 want=1", name);
    end
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL %s_busy got=%b want=1", name, busy);
    end
    @(negedge CLK);
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_pulse got=%b%b want=00", name, done, busy);
    end
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL %s_pending got=%0d want=0", name, sb_q.size());
    end
  endtask

  task automatic test_reset;
    reset    = 1'b1;
    start    = 1'b0;
    base_addr = '0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_op    = '0;
    in_rd    = '0;
    in_rn    = '0;
    in_rm    = '0;
    in_imm   = '0;
    in_hw    = '0;
    exp_addr = '0;
    repeat (3) @(posedge CLK);
    #1;
    total++;
    if ({in_ready, imem_we, busy, done, err} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b want=00000",
               {in_ready, imem_we, busy, done, err});
    end
    total++;
    if (count !== 3'd0 || imem_addr !== 64'd0 || imem_wdata !== 32'd0) begin
      bad++;
      $display("FAIL reset_regs got=%0d/%h/%h want=0/0/0",
               count, imem_addr, imem_wdata);
    end
    reset = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_encode;
    do_start(64'h1000);
    start     = 1'b1;
    base_addr = 64'hDEAD_0000;
    beat(4'd0, 5'd3, 5'd1, 5'd2, 26'd0, 2'd0, 1'b0, 1'b1, 32'h8B020023);
    start    = 1'b0;
    in_valid = 1'b0;
    @(negedge CLK);
    total++;
    if (count !== 3'd1) begin
      bad++;
      $display("FAIL first_count got=%0d want=1", count);
    end
    @(posedge CLK); #1;
    beat(4'd4, 5'd5, 5'd6, 5'd0, 26'd8, 2'd0, 1'b0, 1'b1, 32'hF84080C5);
    beat(4'd5, 5'd5, 5'd6, 5'd0, 26'd8, 2'd0, 1'b0, 1'b1, 32'hF80080C5);
    beat(4'd7, 5'd0, 5'd0, 5'd0, 26'h3FFFFFF, 2'd0, 1'b1, 1'b1,
         32'h17FFFFFF);
    in_valid = 1'b0;
    wait_done("encode1");
    total++;
    if (count !== 3'd4 || err !== 1'b0) begin
      bad++;
      $display("FAIL encode1_end got=%0d/%b want=4/0", count, err);
    end
    do_start(64'hFFFF_FFFF_FFFF_FFFC);
    beat(4'd6, 5'd7, 5'd0, 5'd0, 26'd4, 2'd0, 1'b0, 1'b1, 32'hB4000087);
    beat(4'd8, 5'd9, 5'd0, 5'd0, 26'h1234, 2'd1, 1'b1, 1'b1,
         32'hD2A24689);
    in_valid = 1'b0;
    wait_done("encode2");
    total++;
    if (count !== 3'd2 || err !== 1'b0) begin
      bad++;
      $display("FAIL encode2_end got=%0d/%b want=2/0", count, err);
    end
  endtask

  task automatic test_range_error;
    do_start(64'h2000);
    beat(4'd4, 5'd5, 5'd6, 5'd0, 26'd300, 2'd0, 1'b0, 1'b0, 32'd0);
    beat(4'd0, 5'd3, 5'd1, 5'd2, 26'd0, 2'd0, 1'b1, 1'b1, 32'h8B020023);
    in_valid = 1'b0;
    wait_done("range");
    total++;
    if (err !== 1'b1 || count !== 3'd1) begin
      bad++;
      $display("FAIL range_end got=%b/%0d want=1/1", err, count);
    end
  endtask

  task automatic test_illegal;
    do_start(64'h4000);
    total++;
    if (err !== 1'b0 || count !== 3'd0) begin
      bad++;
      $display("FAIL start_clear got=%b/%0d want=0/0", err, count);
    end
    beat(4'd6, 5'd1, 5'd0, 5'd0, 26'h0040000, 2'd0, 1'b0, 1'b0, 32'd0);
    beat(4'd9, 5'd1, 5'd2, 5'd3, 26'd0, 2'd0, 1'b1, 1'b0, 32'd0);
    in_valid = 1'b0;
    wait_done("illegal");
    total++;
    if (err !== 1'b1 || count !== 3'd0) begin
      bad++;
      $display("FAIL illegal_end got=%b/%0d want=1/0", err, count);
    end
  endtask

  task automatic test_back_to_back_overflow;
    int acc;
    int seen;
    acc  = 0;
    seen = 0;
    do_start(64'h3000);
    in_op    = 4'd1;
    in_rd    = 5'd4;
    in_rn    = 5'd5;
    in_rm    = 5'd6;
    in_imm   = '0;
    in_hw    = '0;
    in_last  = 1'b0;
    in_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      if (in_ready === 1'b1) begin
        sb_q.push_back({exp_addr, 32'hCB0600A4});
        exp_addr = exp_addr + 64'd4;
        acc++;
      end
      @(posedge CLK); #1;
      if (done === 1'b1) begin
        seen = 1;
        break;
      end
    end
    in_valid = 1'b0;
    total++;
    if (acc != 4) begin
      bad++;
      $display("FAIL ovf_accepts got=%0d want=4", acc);
    end
    total++;
    if (seen != 1 || err !== 1'b1) begin
      bad++;
      $display("FAIL ovf_end got=%0d/%b want=1/1", seen, err);
    end
    @(posedge CLK); #1;
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || sb_q.size() != 0) begin
      bad++;
      $display("FAIL ovf_idle got=%b%b/%0d want=00/0",
               done, busy, sb_q.size());
    end
  endtask

  task automatic test_reset_mid;
    do_start(64'h5000);
    beat(4'd2, 5'd1, 5'd2, 5'd3, 26'd0, 2'd0, 1'b0, 1'b1, 32'h8A030041);
    reset = 1'b1;
    @(posedge CLK); #1;
    total++;
    if ({imem_we, busy, in_ready} !== 3'b000 || count !== 3'd0) begin
      bad++;
      $display("FAIL mid_reset got=%b/%0d want=000/0",
               {imem_we, busy, in_ready}, count);
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    total++;
    if (busy !== 1'b0 || sb_q.size() != 0) begin
      bad++;
      $display("FAIL post_reset got=%b/%0d want=0/0", busy, sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_encode();
    test_range_error();
    test_illegal();
    test_back_to_back_overflow();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
